add_compare_select_unit: RTL and testbench
==========================================

ADD_COMPARE_SELECT_UNIT -- requirements
Module: add_compare_select_unit

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 2, giving the branch-metric and path-metric width in bits.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1 bit: a high level enables the path-metric update on the current edge.
REQ-005 SHALL have port i_data, input, 2 bits: the received hard-decision symbol pair.
REQ-006 SHALL have ports o_BM_0..o_BM_3, output, SIZE_DATA bits each: combinational branch metrics.
REQ-007 SHALL have ports o_PM_0..o_PM_3, output, SIZE_DATA bits each: registered path metrics for states 0..3.
REQ-008 SHALL have port o_dec, output, 4 bits: combinational survivor decision, bit s for state s.

Function
REQ-009 SHALL compute o_BM_k = popcount(i_data XOR k) for k = 0..3, i.e. the Hamming distance to the codeword whose value is k; range 0..2.
REQ-010 SHALL form each candidate as a SIZE_DATA+1-bit sum, saturated to MAX = 2^SIZE_DATA-1 (3 at the default width).
REQ-011 SHALL form candidate pairs from the current o_PM values:
- state 0: (BM0+PM0, BM3+PM1)
- state 1: (BM2+PM2, BM1+PM3)
- state 2: (BM3+PM0, BM0+PM1)
- state 3: (BM1+PM2, BM2+PM3)
REQ-012 SHALL select the smaller saturated candidate of each pair; on a tie, the first candidate SHALL win.
REQ-013 SHALL drive o_dec[s] = 0 when the first candidate of state s is selected, 1 otherwise.
REQ-014 SHALL load the selected values into the o_PM registers on a rising edge when i_valid=1 and i_rst=0; latency one cycle.
REQ-015 SHALL hold o_PM unchanged when i_valid=0; o_BM and o_dec still track the inputs combinationally.
REQ-016 SHALL never wrap path metrics: a saturated value stays at MAX until a smaller candidate is selected.

Reset
REQ-017 SHALL, on a rising edge with i_rst=1, set o_PM_0=0 and o_PM_1..o_PM_3=MAX, regardless of i_valid.
REQ-018 SHALL give reset priority over an update in the same cycle; reset mid-stream discards all accumulated metrics.

Configuration
REQ-019 SHALL support macro ACS_NORMALIZE_EN.
REQ-020 SHALL, with ACS_NORMALIZE_EN defined, subtract the minimum of the four selected values from each of them before the register load, so at least one o_PM is 0 after every update.
REQ-021 SHALL, without ACS_NORMALIZE_EN, register the selected values unmodified; o_BM and o_dec are identical in both builds.

Structure
REQ-022 SHALL place in a shared package:
- constant NUM_STATES=4;
- the state-transition tables (predecessor pairs and branch-metric indices per state);
- the saturate and min helper functions.
REQ-023 SHALL implement one sub-module, acs_cell (two adders, saturation, compare, select, decision bit), instantiated once per state.
REQ-024 SHALL compute branch metrics combinationally in the top level and keep the path-metric register bank in the top level.

Verification
REQ-025 SHALL cover reset: i_rst=1 for 2 edges -> o_PM = {0,3,3,3}.
REQ-026 SHALL cover the first update: i_valid=1, i_data=00 -> o_BM = {0,1,1,2}, o_dec=0000; after one edge o_PM = {0,3,2,3}.
REQ-027 SHALL cover the next update: from there, i_data=01 -> o_BM = {1,0,2,1}, o_dec=0000; after the edge o_PM = {1,3,1,2} without the macro, {0,2,0,1} with ACS_NORMALIZE_EN.
REQ-028 SHALL cover hold: i_valid=0, i_data=11 for 3 edges -> o_PM unchanged; o_BM = {2,1,1,0}.
REQ-029 SHALL cover saturation and ties: o_PM={3,3,3,3}, i_data=11 -> no candidate exceeds 3, o_dec=0000, o_PM stays {3,3,3,3}.
REQ-030 SHALL cover reset priority: i_rst=1 with i_valid=1 mid-stream -> o_PM = {0,3,3,3} on that edge.

Source files
------------

// File: rtl/add_compare_select_unit_pkg.sv
// Shared trellis description for the 4-state ACS: state count, predecessor/branch tables, helpers.
// Pure constants and functions; no latency, no flow control.
package add_compare_select_unit_pkg;

   localparam int NUM_STATES = 4;

   // Candidate A/B of state s: PM[PRED_x[s]] + BM[BM_x[s]]
   localparam int PRED_A [NUM_STATES] = '{0, 2, 0, 2};
   localparam int PRED_B [NUM_STATES] = '{1, 3, 1, 3};
   localparam int BM_A   [NUM_STATES] = '{0, 2, 3, 1};
   localparam int BM_B   [NUM_STATES] = '{3, 1, 0, 2};

   function automatic int unsigned sat(input int unsigned v, input int unsigned max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   function automatic int unsigned min2(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/add_compare_select_unit_acs_cell.sv
// One ACS butterfly half: two saturating adds, compare, select and decision bit.
// Purely combinational (0 cycles); no backpressure.
module acs_cell #(
   parameter int SIZE_DATA = 2
) (
   input  logic [SIZE_DATA-1:0] pm_a,
   input  logic [SIZE_DATA-1:0] bm_a,
   input  logic [SIZE_DATA-1:0] pm_b,
   input  logic [SIZE_DATA-1:0] bm_b,
   output logic [SIZE_DATA-1:0] pm_sel,
   output logic                 dec
);
   import add_compare_select_unit_pkg::*;

   localparam int unsigned MAX_U = (2**SIZE_DATA) - 1;

   logic [SIZE_DATA:0]   sum_a;
   logic [SIZE_DATA:0]   sum_b;
   logic [SIZE_DATA-1:0] sat_a;
   logic [SIZE_DATA-1:0] sat_b;

   assign sum_a = {1'b0, pm_a} + {1'b0, bm_a};
   assign sum_b = {1'b0, pm_b} + {1'b0, bm_b};
   assign sat_a = SIZE_DATA'(sat(32'(sum_a), MAX_U));
   assign sat_b = SIZE_DATA'(sat(32'(sum_b), MAX_U));

   // Strict compare so a tie keeps the first candidate
   assign dec    = (sat_b < sat_a);
   assign pm_sel = dec ? sat_b : sat_a;

endmodule

// File: rtl/add_compare_select_unit.sv
// 4-state add-compare-select: combinational BM/decisions, path metrics registered with 1-cycle latency
// when i_valid is high (held otherwise); ACS_NORMALIZE_EN rebases metrics so the minimum is 0.
module add_compare_select_unit #(
   parameter int SIZE_DATA = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic [1:0]           i_data,
   output logic [SIZE_DATA-1:0] o_BM_0,
   output logic [SIZE_DATA-1:0] o_BM_1,
   output logic [SIZE_DATA-1:0] o_BM_2,
   output logic [SIZE_DATA-1:0] o_BM_3,
   output logic [SIZE_DATA-1:0] o_PM_0,
   output logic [SIZE_DATA-1:0] o_PM_1,
   output logic [SIZE_DATA-1:0] o_PM_2,
   output logic [SIZE_DATA-1:0] o_PM_3,
   output logic [3:0]           o_dec
);
   import add_compare_select_unit_pkg::*;

   localparam logic [SIZE_DATA-1:0] PM_MAX = '1;

   logic [SIZE_DATA-1:0]  bm     [NUM_STATES];
   logic [SIZE_DATA-1:0]  pm_q   [NUM_STATES];
   logic [SIZE_DATA-1:0]  pm_sel [NUM_STATES];
   logic [SIZE_DATA-1:0]  pm_d   [NUM_STATES];
   logic [NUM_STATES-1:0] dec_w;

   // Hamming distance between the received pair and codeword k
   for (genvar k = 0; k < NUM_STATES; k++) begin : g_bm
      localparam logic [1:0] CW = 2'(k);
      assign bm[k] = SIZE_DATA'(i_data[0] ^ CW[0]) + SIZE_DATA'(i_data[1] ^ CW[1]);
   end

   for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
      acs_cell #(
         .SIZE_DATA (SIZE_DATA)
      ) u_acs_cell (
         .pm_a   (pm_q[PRED_A[s]]),
         .bm_a   (bm[BM_A[s]]),
         .pm_b   (pm_q[PRED_B[s]]),
         .bm_b   (bm[BM_B[s]]),
         .pm_sel (pm_sel[s]),
         .dec    (dec_w[s])
      );
   end

`ifdef ACS_NORMALIZE_EN
   logic [SIZE_DATA-1:0] pm_min;

   always_comb begin
      pm_min = SIZE_DATA'(min2(min2(32'(pm_sel[0]), 32'(pm_sel[1])),
                               min2(32'(pm_sel[2]), 32'(pm_sel[3]))));
      for (int s = 0; s < NUM_STATES; s++) begin
         pm_d[s] = pm_sel[s] - pm_min;
      end
   end
`else
   always_comb begin
      for (int s = 0; s < NUM_STATES; s++) begin
         pm_d[s] = pm_sel[s];
      end
   end
`endif

   // State 0 is the known start state; all others begin at the worst metric
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pm_q[0] <= '0;
         for (int s = 1; s < NUM_STATES; s++) begin
            pm_q[s] <= PM_MAX;
         end
      end else if (i_valid) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            pm_q[s] <= pm_d[s];
         end
      end
   end

   assign o_BM_0 = bm[0];
   assign o_BM_1 = bm[1];
   assign o_BM_2 = bm[2];
   assign o_BM_3 = bm[3];
   assign o_PM_0 = pm_q[0];
   assign o_PM_1 = pm_q[1];
   assign o_PM_2 = pm_q[2];
   assign o_PM_3 = pm_q[3];
   assign o_dec  = dec_w;

endmodule

// File: tb/tb_add_compare_select_unit.sv
// Directed bench for add_compare_select_unit: hand-computed metric and decision vectors.
// Expected values follow the default build, with the normalised alternative under ACS_NORMALIZE_EN.
module tb_add_compare_select_unit;

   logic       i_clk;
   logic       i_rst;
   logic       i_valid;
   logic [1:0] i_data;
   logic [1:0] o_BM_0, o_BM_1, o_BM_2, o_BM_3;
   logic [1:0] o_PM_0, o_PM_1, o_PM_2, o_PM_3;
   logic [3:0] o_dec;

   int checks = 0;
   int errors = 0;

   add_compare_select_unit #(
      .SIZE_DATA (2)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_BM_0  (o_BM_0),
      .o_BM_1  (o_BM_1),
      .o_BM_2  (o_BM_2),
      .o_BM_3  (o_BM_3),
      .o_PM_0  (o_PM_0),
      .o_PM_1  (o_PM_1),
      .o_PM_2  (o_PM_2),
      .o_PM_3  (o_PM_3),
      .o_dec   (o_dec)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] pk(input int a, input int b, input int c, input int d);
      return {2'(a), 2'(b), 2'(c), 2'(d)};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_pm(input string tag, input logic [7:0] exp);
      check(tag, {o_PM_0, o_PM_1, o_PM_2, o_PM_3}, exp);
   endtask

   task automatic chk_bm(input string tag, input logic [7:0] exp);
      check(tag, {o_BM_0, o_BM_1, o_BM_2, o_BM_3}, exp);
   endtask

   task automatic chk_dec(input string tag, input logic [3:0] exp);
      check(tag, {4'b0, o_dec}, {4'b0, exp});
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = 2'b00;
      tick();
      tick();
      chk_pm("reset_pm", pk(0, 3, 3, 3));

      // First update
      i_rst   = 1'b0;
      i_valid = 1'b1;
      i_data  = 2'b00;
      #1;
      chk_bm("upd1_bm", pk(0, 1, 1, 2));
      chk_dec("upd1_dec", 4'b0000);
      tick();
      chk_pm("upd1_pm", pk(0, 3, 2, 3));

      // Second update
      i_data = 2'b01;
      #1;
      chk_bm("upd2_bm", pk(1, 0, 2, 1));
      chk_dec("upd2_dec", 4'b0000);
      tick();
`ifdef ACS_NORMALIZE_EN
      chk_pm("upd2_pm", pk(0, 2, 0, 1));
`else
      chk_pm("upd2_pm", pk(1, 3, 1, 2));
`endif

      // Hold with valid low
      i_valid = 1'b0;
      i_data  = 2'b11;
      #1;
      chk_bm("hold_bm", pk(2, 1, 1, 0));
      chk_dec("hold_dec", 4'b0000);
      for (int i = 0; i < 3; i++) begin
         tick();
`ifdef ACS_NORMALIZE_EN
         chk_pm("hold_pm", pk(0, 2, 0, 1));
`else
         chk_pm("hold_pm", pk(1, 3, 1, 2));
`endif
      end

      i_valid = 1'b1;
`ifdef ACS_NORMALIZE_EN
      i_data = 2'b11;
      tick();
      chk_pm("norm_pm", pk(2, 1, 0, 1));
`else
      // Drive metrics up to saturation in every state
      i_data = 2'b10;
      tick();
      chk_pm("climb_a_pm", pk(2, 1, 2, 2));
      i_data = 2'b01;
      #1;
      chk_dec("climb_b_dec", 4'b0111);
      tick();
      chk_pm("climb_b_pm", pk(2, 2, 2, 2));
      i_data = 2'b00;
      #1;
      chk_dec("climb_c_dec", 4'b0100);
      tick();
      chk_pm("climb_c_pm", pk(2, 3, 2, 3));
      i_data = 2'b01;
      tick();
      chk_pm("climb_d_pm", pk(3, 3, 3, 2));
      i_data = 2'b00;
      tick();
      chk_pm("climb_e_pm", pk(3, 3, 3, 3));

      // Saturated metrics: every pair ties at MAX
      i_data = 2'b11;
      #1;
      chk_bm("sat_bm", pk(2, 1, 1, 0));
      chk_dec("sat_dec", 4'b0000);
      tick();
      chk_pm("sat_pm", pk(3, 3, 3, 3));
`endif

      // Reset wins over a simultaneous update
      i_rst   = 1'b1;
      i_valid = 1'b1;
      i_data  = 2'b00;
      tick();
      chk_pm("rst_prio_pm", pk(0, 3, 3, 3));
      i_rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
